// File: rtl/regfile4x32.sv
// Four-entry register file with two combinational read ports, write-back bypass,
// a per-register busy scoreboard for reservations, and a wrapping write counter.
module regfile4x32 #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        rd_reg1,
    input  logic [1:0]        rd_reg2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wr_en,
    input  logic [1:0]        wr_reg,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [1:0]        rsv_reg,
    output logic [3:0]        busy,
    output logic              rsv_conflict,
    output logic [7:0]        wr_count
);

    logic [3:0][DATA_W-1:0] regs_q, regs_d;
    logic [3:0]             busy_q, busy_d;
    logic                   rsv_conflict_q, rsv_conflict_d;
    logic [7:0]             wr_count_q, wr_count_d;
    logic [3:0]             wr_dec, rsv_dec;

    function automatic logic [3:0] dec2to4(input logic en, input logic [1:0] sel);
        dec2to4 = 4'b0000;
        if (en) dec2to4[sel] = 1'b1;
    endfunction

    // A register being written this cycle is seen with its new value, even in reset.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [1:0]             sel,
        input logic [3:0]             wdec,
        input logic [DATA_W-1:0]      wdata,
        input logic [3:0][DATA_W-1:0] regs
    );
        read_port = wdec[sel] ? wdata : regs[sel];
    endfunction

    always_comb begin
        wr_dec  = dec2to4(wr_en, wr_reg);
        rsv_dec = dec2to4(rsv_en, rsv_reg);
    end

    always_comb begin
        rd_data1 = read_port(rd_reg1, wr_dec, wr_data, regs_q);
        rd_data2 = read_port(rd_reg2, wr_dec, wr_data, regs_q);
        rd_busy1 = busy_q[rd_reg1] & ~wr_dec[rd_reg1];
        rd_busy2 = busy_q[rd_reg2] & ~wr_dec[rd_reg2];
    end

    // Reservation takes priority over write-back when both target the same register.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int i = 0; i < 4; i++) begin
            if (wr_dec[i]) regs_d[i] = wr_data;
            if (rsv_dec[i]) begin
                busy_d[i] = 1'b1;
            end else if (wr_dec[i]) begin
                busy_d[i] = 1'b0;
            end
        end
        rsv_conflict_d = rsv_en & busy_q[rsv_reg] & ~wr_dec[rsv_reg];
        wr_count_d     = wr_en ? wr_count_q + 8'd1 : wr_count_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs_q         <= '0;
            busy_q         <= 4'b0000;
            rsv_conflict_q <= 1'b0;
            wr_count_q     <= 8'd0;
        end else begin
            regs_q         <= regs_d;
            busy_q         <= busy_d;
            rsv_conflict_q <= rsv_conflict_d;
            wr_count_q     <= wr_count_d;
        end
    end

    assign busy         = busy_q;
    assign rsv_conflict = rsv_conflict_q;
    assign wr_count     = wr_count_q;

endmodule

// File: tb/tb_regfile4x32.sv
// Bench for regfile4x32: array-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_regfile4x32;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [1:0]  rd_reg1 = '0, rd_reg2 = '0, wr_reg = '0, rsv_reg = '0;
    logic [31:0] rd_data1, rd_data2, wr_data = '0;
    logic        rd_busy1, rd_busy2, wr_en = 1'b0, rsv_en = 1'b0;
    logic [3:0]  busy;
    logic        rsv_conflict;
    logic [7:0]  wr_count;

    int n_vec  = 0;
    int n_miss = 0;

    regfile4x32 #(.DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .rd_reg1(rd_reg1), .rd_reg2(rd_reg2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
        .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_reg(rsv_reg),
        .busy(busy), .rsv_conflict(rsv_conflict), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    // Reference model: plain arrays updated by the architectural rules.
    logic [31:0] m_reg [4] = '{32'd0, 32'd0, 32'd0, 32'd0};
    logic        m_busy[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic        m_conf = 1'b0;
    logic [7:0]  m_cnt = 8'd0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                m_reg[i]  = 32'd0;
                m_busy[i] = 1'b0;
            end
            m_conf = 1'b0;
            m_cnt  = 8'd0;
        end else begin
            m_conf = rsv_en && m_busy[rsv_reg] && !(wr_en && wr_reg == rsv_reg);
            if (wr_en) begin
                m_reg[wr_reg]  = wr_data;
                m_busy[wr_reg] = 1'b0;
                m_cnt          = m_cnt + 8'd1;
            end
            if (rsv_en) m_busy[rsv_reg] = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [1:0] sel);
        return (wr_en && wr_reg == sel) ? wr_data : m_reg[sel];
    endfunction

    function automatic logic exp_rbusy(input logic [1:0] sel);
        return m_busy[sel] && !(wr_en && wr_reg == sel);
    endfunction

    function automatic logic [3:0] exp_busy();
        return {m_busy[3], m_busy[2], m_busy[1], m_busy[0]};
    endfunction

    always @(negedge clk) begin
        check("rd_data1", rd_data1, exp_rd(rd_reg1));
        check("rd_data2", rd_data2, exp_rd(rd_reg2));
        check("rd_busy1", 32'(rd_busy1), 32'(exp_rbusy(rd_reg1)));
        check("rd_busy2", 32'(rd_busy2), 32'(exp_rbusy(rd_reg2)));
        check("busy", 32'(busy), 32'(exp_busy()));
        check("rsv_conflict", 32'(rsv_conflict), 32'(m_conf));
        check("wr_count", 32'(wr_count), 32'(m_cnt));
    end

    task automatic set_in(input logic we, input logic [1:0] wr, input logic [31:0] wd,
                          input logic re, input logic [1:0] rr,
                          input logic [1:0] r1, input logic [1:0] r2);
        wr_en = we; wr_reg = wr; wr_data = wd;
        rsv_en = re; rsv_reg = rr;
        rd_reg1 = r1; rd_reg2 = r2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] vals[4] = '{32'hAFAFAFAF, 32'hBFAFAFAF, 32'hCFAFAFAF, 32'hDFAFAFAF};

    initial begin
        #1 reset_n = 1'b0;
        #2;
        check("reset busy", 32'(busy), 32'h0);
        check("reset wr_count", 32'(wr_count), 32'h0);
        check("reset rd_data1", rd_data1, 32'h0);
        #9 reset_n = 1'b1;
        tick();

        // Fill all four registers, then read back on both ports
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 2'(i), vals[i], 1'b0, 2'd0, 2'd0, 2'd0);
            tick();
        end
        set_in(1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 2'd0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            rd_reg1 = 2'(i);
            rd_reg2 = 2'(3 - i);
            #1;
            check("fill rd_data1", rd_data1, vals[i]);
            check("fill rd_data2", rd_data2, vals[3 - i]);
        end
        check("fill wr_count", 32'(wr_count), 32'd4);
        tick();

        // Same-cycle bypass of a write to R2
        set_in(1'b1, 2'd2, 32'h1, 1'b0, 2'd0, 2'd0, 2'd0);
        tick();
        set_in(1'b1, 2'd2, 32'h55, 1'b0, 2'd0, 2'd2, 2'd2);
        #2;
        check("bypass rd_data1", rd_data1, 32'h55);
        tick();
        set_in(1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 2'd2, 2'd0);
        #2;
        check("bypass stored", rd_data1, 32'h55);
        tick();

        // Reserve R1, then clear it with a write-back
        set_in(1'b0, 2'd0, 32'd0, 1'b1, 2'd1, 2'd1, 2'd0);
        tick();
        set_in(1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 2'd1, 2'd0);
        #2;
        check("rsv busy", 32'(busy), 32'h2);
        check("rsv rd_busy1", 32'(rd_busy1), 32'h1);
        set_in(1'b1, 2'd1, 32'h1234, 1'b0, 2'd0, 2'd1, 2'd0);
        #2;
        check("wb rd_busy1", 32'(rd_busy1), 32'h0);
        check("wb rd_data1", rd_data1, 32'h1234);
        tick();
        set_in(1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 2'd1, 2'd0);
        #2;
        check("wb busy", 32'(busy), 32'h0);

        // Double reservation of R3 flags a one-cycle conflict
        set_in(1'b0, 2'd0, 32'd0, 1'b1, 2'd3, 2'd3, 2'd0);
        tick();
        tick();
        set_in(1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 2'd3, 2'd0);
        #2;
        check("conflict pulse", 32'(rsv_conflict), 32'h1);
        check("conflict busy", 32'(busy), 32'h8);
        tick();
        check("conflict drop", 32'(rsv_conflict), 32'h0);
        set_in(1'b1, 2'd3, 32'h77, 1'b1, 2'd3, 2'd3, 2'd0);
        tick();
        set_in(1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 2'd3, 2'd0);
        #2;
        check("rsv+wr conflict", 32'(rsv_conflict), 32'h0);
        check("rsv+wr busy", 32'(busy), 32'h8);
        check("rsv+wr data", rd_data1, 32'h77);
        check("rsv+wr rd_busy1", 32'(rd_busy1), 32'h1);

        // Reserve R0 while writing R3: both take effect
        set_in(1'b1, 2'd3, 32'h88, 1'b1, 2'd0, 2'd0, 2'd3);
        tick();
        set_in(1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 2'd0, 2'd3);
        #2;
        check("split busy", 32'(busy), 32'h1);
        check("split data", rd_data2, 32'h88);
        check("count before wrap", 32'(wr_count), 32'd9);

        // 256 writes with random traffic: 247 bring the count to zero, 9 more back to 9
        for (int i = 0; i < 256; i++) begin
            set_in(1'b1, 2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            tick();
            if (i == 246) check("wrap to zero", 32'(wr_count), 32'd0);
        end
        check("wrap full", 32'(wr_count), 32'd9);

        // Fill with nonzero data and reserve everything, then reset between edges
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 2'(i), 32'h100 + 32'(i), 1'b1, 2'(i), 2'd0, 2'd0);
            tick();
        end
        set_in(1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 2'd2, 2'd1);
        #2;
        check("all busy", 32'(busy), 32'hF);
        check("pre-reset data", rd_data1, 32'h102);
        reset_n = 1'b0;
        #1;
        check("async busy", 32'(busy), 32'h0);
        check("async wr_count", 32'(wr_count), 32'h0);
        check("async conflict", 32'(rsv_conflict), 32'h0);
        check("async rd_data1", rd_data1, 32'h0);
        set_in(1'b1, 2'd2, 32'hABC, 1'b1, 2'd2, 2'd2, 2'd1);
        #1;
        check("reset bypass", rd_data1, 32'hABC);
        check("reset other", rd_data2, 32'h0);
        tick();
        set_in(1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 2'd2, 2'd1);
        #1;
        check("reset ignores wr", rd_data1, 32'h0);
        check("reset ignores rsv", 32'(busy), 32'h0);
        #2 reset_n = 1'b1;
        tick();
        set_in(1'b1, 2'd1, 32'h999, 1'b0, 2'd0, 2'd1, 2'd0);
        tick();
        set_in(1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 2'd1, 2'd0);
        #2;
        check("post-reset data", rd_data1, 32'h999);
        check("post-reset count", 32'(wr_count), 32'd1);
        check("post-reset busy", 32'(busy), 32'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
